reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 The block SHALL have localparam AW = $clog2(DEPTH), the address width.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port wr_en  input  1  write strobe.
REQ-007 The block SHALL have port wr_addr  input  AW  write address.
REQ-008 The block SHALL have port wr_data  input  WIDTH  write data.
REQ-009 The block SHALL have port rd_req  input  1  read request valid.
REQ-010 The block SHALL have port rd_addr  input  AW  read address, sampled with rd_req.
REQ-011 The block SHALL have port rd_req_ready  output  1  read request accepted this cycle.
REQ-012 The block SHALL have port rd_valid  output  1  read response valid.
REQ-013 The block SHALL have port rd_data  output  WIDTH  read response data.
REQ-014 The block SHALL have port rd_ready  input  1  consumer accepts the response.

Function
REQ-015 Write: when wr_en=1 at a rising edge with rst=0, entry[wr_addr] SHALL take wr_data; the new value is visible to reads accepted from that same edge onward.
REQ-016 rd_req_ready SHALL be combinational: !rd_valid || rd_ready.
REQ-017 A read SHALL be accepted at an edge where rd_req=1, rd_req_ready=1 and rst=0.
REQ-018 Latency SHALL be one cycle: after acceptance, rd_valid=1 on the next cycle, with rd_data equal to entry[rd_addr] as sampled at the acceptance edge.
REQ-019 Read-during-write to the same address at the acceptance edge SHALL be write-first: rd_data = wr_data.
REQ-020 While rd_valid=1 and rd_ready=0, rd_valid and rd_data SHALL hold stable, and no new read SHALL be accepted; writes SHALL proceed, including writes to the pending address.
REQ-021 With rd_valid=1, rd_ready=1 and rd_req=1, the new response SHALL replace the old one in the next cycle, giving one read per cycle sustained.
REQ-022 With rd_valid=1, rd_ready=1 and rd_req=0, rd_valid SHALL drop to 0 in the next cycle; rd_data keeps its last value.
REQ-023 Reads of entries never written since reset SHALL return 0.
REQ-024 Address wrap SHALL NOT occur; all AW-bit addresses are legal.

Reset
REQ-025 While rst=1 at an edge: all entries SHALL be set to 0, rd_valid=0, rd_data=0; wr_en and rd_req SHALL be ignored.
REQ-026 Reset asserted with a response pending SHALL discard it; rd_valid=0 from the next cycle.
REQ-027 rd_req_ready SHALL read 1 during and immediately after reset.

Structure
REQ-028 Package reg_bank_pkg SHALL hold DEFAULT_WIDTH=8, DEFAULT_DEPTH=8 and an addr_t typedef helper for the defaults.
REQ-029 Each entry SHALL be an instance of the existing register module (WIDTH, clk, rst, en, in, out), with en = wr_en && (wr_addr==i).
REQ-030 The read-response stage (rd_valid, rd_data) SHALL be a separate always_ff block in reg_bank; no further sub-modules.

Verification
REQ-031 Reset test: after 5 cycles of rst, read all 8 addresses -> each rd_data=0x00, rd_valid exactly 1 cycle after each acceptance.
REQ-032 Write-then-read test: write 0xA5 to address 3; read address 3 on the next cycle -> rd_data=0xA5 one cycle later.
REQ-033 Collision test: same edge wr_en addr 5 data 0x3C and rd_req addr 5 (old value 0x11) -> rd_data=0x3C.
REQ-034 Backpressure test: accept read of address 2 (0x77), hold rd_ready=0 for 4 cycles while writing 0xFF to address 2 -> rd_data stays 0x77, rd_req_ready=0 throughout; rd_ready=1 -> response consumed, next read returns 0xFF.
REQ-035 Streaming test: rd_ready=1, rd_req every cycle for addresses 0..7 holding i*0x11 -> responses 0x00..0x77 in order, back-to-back.
REQ-036 Reset-mid-read test: rst=1 while rd_valid=1 and rd_ready=0 -> rd_valid=0 next cycle, all entries read back 0 afterward; random 10000-cycle run checked against a reference model.

Source files
------------

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Purpose  : Shared defaults and address type for the reg_bank register file.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  // Address of one entry in a bank built with the default geometry
  typedef logic [DEFAULT_AW-1:0] addr_t;

endpackage : reg_bank_pkg
`default_nettype wire

// File: rtl/reg_bank_register.sv
`default_nettype none
// ============================================================================
// Module   : register
// Purpose  : One storage entry of the bank: loads 'in' when 'en' is high,
//            clears synchronously on rst.
// Revision : 1.0 - initial release
// ============================================================================
module register
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Next value: load on enable, otherwise hold
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = in;
    end
  end

  // Storage flop with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : register
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Purpose  : DEPTH x WIDTH register file with a direct write port and a
//            one-cycle-latency read port using a valid/ready response stage.
//            Same-edge read/write of one address returns the written data.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_req_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  logic [DEPTH-1:0] entry_en;
  logic [WIDTH-1:0] entry_q [DEPTH];

  logic             rd_accept;
  logic [WIDTH-1:0] rd_word;
  logic             rd_valid_q;
  logic             rd_valid_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Per-entry write enables decoded from the write address
  always_comb begin
    entry_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_en[i] = wr_en && (wr_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    register #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk (clk),
      .rst (rst),
      .en  (entry_en[g]),
      .in  (wr_data),
      .out (entry_q[g])
    );
  end

  // The response slot is free when empty or being drained this cycle. It is
  // also forced free during reset, since any pending response is discarded.
  assign rd_req_ready = rst || !rd_valid_q || rd_ready;
  assign rd_accept    = rd_req && rd_req_ready;

  // Read word with write-first bypass for a same-edge write to the read address
  always_comb begin
    rd_word = entry_q[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_word = wr_data;
    end
  end

  // Response stage next state: load on accept, drop on drain, else hold
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_accept) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_word;
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // Response stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank
// Purpose  : Self-checking bench for reg_bank: directed vector table,
//            hand-written sequences and a long randomised run against a
//            cycle model with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready = 1'b1;
  logic          rd_req_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;

  reg_bank #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_req_ready (rd_req_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] mem [D];
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_data  = '0;
  logic [W-1:0] sb_q [$];
  logic         seen_ready;

  typedef struct {
    logic          r;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          rq;
    logic [AW-1:0] ra;
    logic          rr;
    logic          e_ready;
    logic          e_valid;
    logic [W-1:0]  e_data;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational ready and any
  // response consumed at this edge, advance the model, then check outputs.
  task automatic cycle(input logic r, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic rq,
                       input logic [AW-1:0] ra, input logic rr);
    logic         e_ready;
    logic [W-1:0] rv;
    logic [W-1:0] got;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = ra; rd_ready = rr;
    #1;
    e_ready    = r || !exp_valid || rr;
    seen_ready = rd_req_ready;
    chk("rd_req_ready", 32'(rd_req_ready), 32'(e_ready));
    if (!r && exp_valid && rr) begin
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'(sb_q.size()), 32'(1));
      end else begin
        got = sb_q.pop_front();
        chk("sb_rd_data", 32'(rd_data), 32'(got));
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < D; i++) mem[i] = '0;
      exp_valid = 1'b0;
      exp_data  = '0;
      sb_q.delete();
    end else begin
      if (rq && e_ready) begin
        rv = (we && (wa == ra)) ? wd : mem[ra];
        exp_valid = 1'b1;
        exp_data  = rv;
        sb_q.push_back(rv);
      end else if (rr) begin
        exp_valid = 1'b0;
      end
      if (we) mem[wa] = wd;
    end
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_data", 32'(rd_data), 32'(exp_data));
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = '0;

    //             r  we wa  wd     rq ra rr | rdy vld data
    tbl[0]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'hA5};
    tbl[3]  = '{1'b0, 1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 8'h3C};
    tbl[4]  = '{1'b0, 1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h3C};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 8'h77};
    tbl[6]  = '{1'b0, 1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[7]  = '{1'b0, 1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[8]  = '{1'b0, 1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[9]  = '{1'b0, 1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h77};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 8'hFF};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'hFF};

    // Reset for 5 cycles, then read every address back as zero
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      chk("reset_ready", 32'(seen_ready), 32'(1));
    end
    chk("reset_valid", 32'(rd_valid), 32'(0));
    chk("reset_data", 32'(rd_data), 32'(0));
    for (int a = 0; a < D; a++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(a), 1'b1);
      chk("reset_read_valid", 32'(rd_valid), 32'(1));
      chk("reset_read_data", 32'(rd_data), 32'(0));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk("idle_valid", 32'(rd_valid), 32'(0));

    // Write-then-read, collision and backpressure vectors
    for (int v = 0; v < 13; v++) begin
      cycle(tbl[v].r, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].rq, tbl[v].ra, tbl[v].rr);
      chk($sformatf("vec%0d_ready", v), 32'(seen_ready), 32'(tbl[v].e_ready));
      chk($sformatf("vec%0d_valid", v), 32'(rd_valid), 32'(tbl[v].e_valid));
      chk($sformatf("vec%0d_data", v), 32'(rd_data), 32'(tbl[v].e_data));
    end

    // Streaming: fill i*0x11, then one read per cycle back-to-back
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, 1'b1, AW'(i), W'(i * 17), 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1);
      chk("stream_valid", 32'(rd_valid), 32'(1));
      chk("stream_data", 32'(rd_data), 32'(i * 17));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Reset while a response is pending and stalled
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 3'd4, 1'b0);
    chk("pend_valid", 32'(rd_valid), 32'(1));
    chk("pend_data", 32'(rd_data), 32'(8'h44));
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 3'd4, 1'b0);
    chk("midrst_ready", 32'(seen_ready), 32'(1));
    chk("midrst_valid", 32'(rd_valid), 32'(0));
    chk("midrst_data", 32'(rd_data), 32'(0));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, AW'(i), 8'hEE, 1'b1, '0, 1'b0);
    for (int a = 0; a < D; a++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(a), 1'b1);
      if (a == 0) chk("postrst_ready", 32'(seen_ready), 32'(1));
      chk("postrst_data", 32'(rd_data), 32'(0));
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Randomised run against the model
    for (int n = 0; n < 10000; n++) begin
      cycle($urandom_range(0, 199) == 0,
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, D - 1)),
            W'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, D - 1)),
            $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_bank
`default_nettype wire
